// File: rtl/scan_sequencer.sv
// Timed 4-bit index sequencer feeding a 4-to-16 one-hot decoder.
// Optional skip mask enabled by defining SCAN_SKIP_MASK_EN.
module scan_sequencer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_cont,
    input  logic             dir_down,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       first,
    input  logic [3:0]       last,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [15:0]      skip_mask,
`endif
    output logic [3:0]       idx,
    output logic             idx_valid,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] cnt, cnt_d, div_q;
    logic [3:0]       idx_q, idx_d, fl_q, ll_q;
    logic             dir_q, cont_q;
    logic             done_q, done_d, wrap_q, wrap_d;
    logic             load;
    logic [15:0]      mask_in, mask_run;
    logic [4:0]       fl_in, ll_in;
    logic [3:0]       nx;

    function automatic logic [3:0] offs(input logic [3:0] f,
                                        input logic [3:0] p,
                                        input logic       dn);
        return dn ? f - p : p - f;
    endfunction

    function automatic logic [3:0] step(input logic [3:0] p,
                                        input logic       dn,
                                        input logic [3:0] k);
        return dn ? p - k : p + k;
    endfunction

    // Nearest live position on the path; bit 4 flags that one exists.
    function automatic logic [4:0] first_live(input logic [3:0]  f,
                                              input logic [3:0]  l,
                                              input logic        dn,
                                              input logic [15:0] m);
        logic [3:0] len, p;
        logic [4:0] r;
        len = offs(f, l, dn);
        r   = {1'b0, f};
        for (int k = 15; k >= 0; k--) begin
            p = step(f, dn, 4'(k));
            if (4'(k) <= len && !m[p]) r = {1'b1, p};
        end
        return r;
    endfunction

    function automatic logic [4:0] last_live(input logic [3:0]  f,
                                             input logic [3:0]  l,
                                             input logic        dn,
                                             input logic [15:0] m);
        logic [3:0] len, p;
        logic [4:0] r;
        len = offs(f, l, dn);
        r   = {1'b0, l};
        for (int k = 0; k < 16; k++) begin
            p = step(f, dn, 4'(k));
            if (4'(k) <= len && !m[p]) r = {1'b1, p};
        end
        return r;
    endfunction

    // Offsets are measured from the first live position so the search
    // never wraps back past the start of the path.
    function automatic logic [3:0] next_live(input logic [3:0]  cur,
                                             input logic [3:0]  fl,
                                             input logic [3:0]  ll,
                                             input logic        dn,
                                             input logic [15:0] m);
        logic [3:0] o, len, p, po, r;
        o   = offs(fl, cur, dn);
        len = offs(fl, ll, dn);
        r   = step(cur, dn, 4'd1);
        for (int k = 15; k >= 1; k--) begin
            p  = step(cur, dn, 4'(k));
            po = offs(fl, p, dn);
            if (po > o && po <= len && !m[p]) r = p;
        end
        return r;
    endfunction

`ifdef SCAN_SKIP_MASK_EN
    logic [15:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else if (load) mask_q <= skip_mask;
    end

    assign mask_in  = skip_mask;
    assign mask_run = mask_q;
`else
    assign mask_in  = '0;
    assign mask_run = '0;
`endif

    assign fl_in = first_live(first, last, dir_down, mask_in);
    assign ll_in = last_live(first, last, dir_down, mask_in);
    assign nx    = next_live(idx_q, fl_q, ll_q, dir_q, mask_run);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            div_q  <= '0;
            fl_q   <= '0;
            ll_q   <= '0;
            dir_q  <= 1'b0;
            cont_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            idx_q  <= idx_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            if (load) begin
                div_q  <= div;
                fl_q   <= fl_in[3:0];
                ll_q   <= ll_in[3:0];
                dir_q  <= dir_down;
                cont_q <= mode_cont;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && fl_in[4]) begin
                    state_d = RUN;
                    idx_d   = fl_in[3:0];
                    cnt_d   = div;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (idx_q != ll_q) begin
                    idx_d = nx;
                    cnt_d = div_q;
                end else if (cont_q) begin
                    idx_d  = fl_q;
                    cnt_d  = div_q;
                    wrap_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx       = idx_q;
        busy      = (state == RUN);
        idx_valid = (state == RUN);
        done      = done_q;
        wrap      = wrap_q;
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed table-driven bench for scan_sequencer.
// Skip-mask vectors run when SCAN_SKIP_MASK_EN is defined.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, mode_cont, dir_down;
    logic [7:0] div;
    logic [3:0] first, last;
`ifdef SCAN_SKIP_MASK_EN
    logic [15:0] skip_mask;
`endif
    logic [3:0] idx;
    logic       idx_valid, busy, done, wrap;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       st, sp, mc, dd;
        logic [7:0] dv;
        logic [3:0] f, l;
        logic [3:0] ei;
        logic       ev, ed, ew;
    } vec_t;

    vec_t tbl[$];

    scan_sequencer #(.DIV_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dir_down  (dir_down),
        .div       (div),
        .first     (first),
        .last      (last),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask (skip_mask),
`endif
        .idx       (idx),
        .idx_valid (idx_valid),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic mc,
                       input logic dd, input logic [7:0] dv,
                       input logic [3:0] f, input logic [3:0] l,
                       input logic [3:0] ei, input logic ev,
                       input logic ed, input logic ew);
        vec_t v;
        v.st = st; v.sp = sp; v.mc = mc; v.dd = dd; v.dv = dv;
        v.f = f; v.l = l; v.ei = ei; v.ev = ev; v.ed = ed; v.ew = ew;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic st, input logic sp, input logic mc,
                         input logic dd, input logic [7:0] dv,
                         input logic [3:0] f, input logic [3:0] l);
        start = st; stop = sp; mode_cont = mc; dir_down = dd;
        div = dv; first = f; last = l;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {idx, idx_valid, busy, done, wrap};
    endfunction

    initial begin
        int n, errs, dn;

        // single-shot 2..5 up, div=1
        add(1, 0, 0, 0, 1, 2, 5, 2, 1, 0, 0);
        for (int i = 1; i < 8; i++)
            add(0, 0, 0, 0, 1, 2, 5, 4'(2 + i / 2), 1, 0, 0);
        add(0, 0, 0, 0, 1, 2, 5, 5, 0, 1, 0);
        add(0, 0, 0, 0, 1, 2, 5, 5, 0, 0, 0);
        // 14..1 up through wrap
        add(1, 0, 0, 0, 0, 14, 1, 14, 1, 0, 0);
        add(0, 0, 0, 0, 0, 14, 1, 15, 1, 0, 0);
        add(0, 0, 0, 0, 0, 14, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 14, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 14, 1, 1, 0, 1, 0);
        // 1..14 down through wrap
        add(1, 0, 0, 1, 0, 1, 14, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 14, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 14, 15, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 14, 14, 1, 0, 0);
        add(0, 0, 0, 1, 0, 1, 14, 14, 0, 1, 0);
        // start with stop while idle
        add(1, 1, 0, 0, 0, 3, 3, 14, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3, 3, 14, 0, 0, 0);
        // start and config changes during run are ignored
        add(1, 0, 0, 0, 0, 2, 4, 2, 1, 0, 0);
        add(1, 0, 1, 1, 3, 9, 12, 3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9, 12, 4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 9, 12, 4, 0, 1, 0);
        // continuous first==last=7, div=2, stop when wrap due
        add(1, 0, 1, 0, 2, 7, 7, 7, 1, 0, 0);
        for (int i = 1; i < 9; i++)
            add(0, 0, 1, 0, 2, 7, 7, 7, 1, 0, (i % 3) == 0);
        add(0, 1, 1, 0, 2, 7, 7, 7, 0, 0, 0);
        add(0, 0, 1, 0, 2, 7, 7, 7, 0, 0, 0);
        // stop beats single-shot completion
        add(1, 0, 0, 0, 0, 3, 3, 3, 1, 0, 0);
        add(0, 1, 0, 0, 0, 3, 3, 3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 3, 3, 3, 0, 0, 0);
        // first==last single-shot, div=0
        add(1, 0, 0, 0, 0, 6, 6, 6, 1, 0, 0);
        add(0, 0, 0, 0, 0, 6, 6, 6, 0, 1, 0);
        add(0, 0, 0, 0, 0, 6, 6, 6, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
`ifdef SCAN_SKIP_MASK_EN
        skip_mask = '0;
`endif
        #12;
        chk("reset outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].mc, tbl[i].dd,
                  tbl[i].dv, tbl[i].f, tbl[i].l);
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].ei, tbl[i].ev, tbl[i].ev,
                     tbl[i].ed, tbl[i].ew}));
        end

        // full 0..15 up scan, div=2: 48 live cycles then done
        drive(1, 0, 0, 0, 2, 0, 15);
        tick();
        drive(0, 0, 0, 0, 2, 0, 15);
        n = 0;
        errs = 0;
        while (idx_valid && n < 200) begin
            if (idx !== 4'(n / 3)) errs++;
            n++;
            tick();
        end
        chk("full scan cycles", 32'(n), 32'd48);
        chk("full scan order", 32'(errs), 32'd0);
        chk("full scan done", 32'({done, idx}), 32'h1f);
        tick();

        // asynchronous reset in the middle of a scan
        drive(1, 0, 0, 0, 3, 0, 15);
        tick();
        drive(0, 0, 0, 0, 3, 0, 15);
        repeat (5) tick();
        chk("mid-run busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", 32'(outs()), 32'h0);
        #3;
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy || wrap) dn++;
        end
        chk("quiet after reset", 32'(dn), 32'd0);

`ifdef SCAN_SKIP_MASK_EN
        skip_mask = 16'h0015;
        drive(1, 0, 0, 0, 0, 0, 5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 5);
        chk("skip idx a", 32'(outs()), 32'({4'd1, 4'b1100}));
        tick();
        chk("skip idx b", 32'(outs()), 32'({4'd3, 4'b1100}));
        tick();
        chk("skip idx c", 32'(outs()), 32'({4'd5, 4'b1100}));
        tick();
        chk("skip done", 32'(outs()), 32'({4'd5, 4'b0010}));
        skip_mask = 16'hFFFF;
        drive(1, 0, 0, 0, 0, 0, 5);
        tick();
        drive(0, 0, 0, 0, 0, 0, 5);
        chk("all masked busy", 32'(busy), 32'd0);
        tick();
        chk("all masked idle", 32'({busy, idx_valid}), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
